// File: rtl/dsp_nco.sv
// dsp_nco: quadrature NCO with phase accumulator, optional LFSR phase dither and octant-symmetric sin/cos lookup.
module dsp_nco #(
    parameter int PHI_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int DITHER_MAX = 255,
    parameter int REG_OUT    = 1,
    parameter     FILE_SIN   = "dsp_nco_rom_sin45.txt",
    parameter     FILE_COS   = "dsp_nco_rom_cos45.txt",
    parameter     METHOD     = "SMALL_ROM"
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [PHI_WIDTH-1:0]         phi_inc,
    input  logic                         dither_en,
    output logic signed [DATA_WIDTH-1:0] sin_o,
    output logic signed [DATA_WIDTH-1:0] cos_o
);
    localparam int QW = ADDR_WIDTH + 3;
    localparam int M = 2 ** (DATA_WIDTH - 1) - 1;
    localparam logic [63:0] PI_Q60 = 64'h3243_F6A8_885A_308D;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    if (METHOD != "SMALL_ROM" || FILE_SIN == "" || FILE_COS == "" || ((DITHER_MAX & (DITHER_MAX + 1)) != 0)) begin : g_bad_cfg
        $error("dsp_nco: unsupported METHOD or invalid DITHER_MAX");
    end

    // Octant tables built from the same formula as the ROM files: round(M*f((k+0.5)*d)), Taylor series in Q60.
    function automatic logic [DATA_WIDTH-1:0] rom_val(input int k, input bit is_cos);
        logic [127:0] x, x2, t, s;
        int n;
        x = (128'(2 * k + 1) * 128'(PI_Q60)) >> (ADDR_WIDTH + 3);
        x2 = (x * x) >> 60;
        t = is_cos ? (128'(1) << 60) : x;
        s = t;
        for (int i = 1; i < 12; i++) begin
            n = is_cos ? 2 * i : 2 * i + 1;
            t = ((t * x2) >> 60) / 128'((n - 1) * n);
            s = ((i & 1) != 0) ? s - t : s + t;
        end
        return DATA_WIDTH'((128'(M) * s + (128'(1) << 59)) >> 60);
    endfunction

    logic [DATA_WIDTH-1:0] sin_rom [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] cos_rom [2**ADDR_WIDTH];

    for (genvar g = 0; g < 2 ** ADDR_WIDTH; g++) begin : g_rom
        assign sin_rom[g] = rom_val(g, 1'b0);
        assign cos_rom[g] = rom_val(g, 1'b1);
    end

    logic [PHI_WIDTH-1:0]  acc, dv;
    logic [31:0]           lfsr;
    logic [QW-1:0]         q;
    logic [2:0]            oct;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rs, rc, xs, xc, ns, nc;
    logic [DATA_WIDTH-1:0] s1_s, s1_c, s2_s, s2_c;

    always_comb begin
        dv = (dither_en && DITHER_MAX > 0) ? PHI_WIDTH'(lfsr & 32'(DITHER_MAX)) : '0;
        q = QW'((acc + dv) >> (PHI_WIDTH - QW));
        oct = q[QW-1 -: 3];
        addr = oct[0] ? ~q[ADDR_WIDTH-1:0] : q[ADDR_WIDTH-1:0];
        rs = sin_rom[addr];
        rc = cos_rom[addr];
        // Octants 1,2,5,6 swap sin/cos; sin negates in the lower half, cos in octants 2..5.
        xs = (oct[0] ^ oct[1]) ? rc : rs;
        xc = (oct[0] ^ oct[1]) ? rs : rc;
        ns = oct[2] ? -xs : xs;
        nc = (oct[2] ^ oct[1]) ? -xc : xc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            lfsr <= SEED;
            s1_s <= '0;
            s1_c <= '0;
            s2_s <= '0;
            s2_c <= '0;
        end else if (en) begin
            acc  <= acc + phi_inc;
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
            s1_s <= ns;
            s1_c <= nc;
            s2_s <= s1_s;
            s2_c <= s1_c;
        end
    end

    assign sin_o = (REG_OUT != 0) ? s2_s : s1_s;
    assign cos_o = (REG_OUT != 0) ? s2_c : s1_c;
endmodule

// File: tb/tb_dsp_nco.sv
// tb_dsp_nco: randomized checks of dsp_nco (REG_OUT=0 and REG_OUT=1) against an ideal rounded-sinusoid model.
module tb_dsp_nco;
    localparam int PW = 32;
    localparam int DW = 16;
    localparam int DMAX = 255;
    localparam int M = 32767;
    localparam real PI = 3.14159265358979323846;
    localparam real D = (PI / 4.0) / 1024.0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic dither_en = 1'b0;
    logic [PW-1:0] phi_inc = '0;
    logic signed [DW-1:0] s0, c0, s1, c1;

    int checks = 0;
    int failures = 0;
    bit [31:0] m_acc, m_lfsr;
    int e0s, e0c, e1s, e1c;
    int S0, C0;

    always #5 clk = ~clk;

    dsp_nco #(.REG_OUT(0)) u0 (.clk(clk), .rst_n(rst_n), .en(en), .phi_inc(phi_inc), .dither_en(dither_en), .sin_o(s0), .cos_o(c0));
    dsp_nco #(.REG_OUT(1)) u1 (.clk(clk), .rst_n(rst_n), .en(en), .phi_inc(phi_inc), .dither_en(dither_en), .sin_o(s1), .cos_o(c1));

    function automatic int rnd(input real v);
        return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    endfunction

    // Ideal angle of the quantized phase, centred in its 2^19-LSB bin.
    function automatic real theta(input bit [31:0] p);
        return (real'(p >> 19) + 0.5) * 2.0 * PI / 8192.0;
    endfunction

    function automatic bit [31:0] next_lfsr(input bit [31:0] v);
        return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_reset;
        m_acc = 0;
        m_lfsr = 32'hACE1_2468;
        e0s = 0; e0c = 0; e1s = 0; e1c = 0;
    endtask

    task automatic tick(input bit e);
        en = e;
        @(posedge clk);
        if (e) begin
            bit [31:0] p;
            p = m_acc + (dither_en ? (m_lfsr & DMAX) : 32'd0);
            e1s = e0s;
            e1c = e0c;
            e0s = rnd(M * $sin(theta(p)));
            e0c = rnd(M * $cos(theta(p)));
            m_acc = m_acc + phi_inc;
            m_lfsr = next_lfsr(m_lfsr);
        end
        #1;
    endtask

    task automatic do_reset;
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (int'(s0) !== 0 || int'(c0) !== 0) begin
            failures++;
            $display("FAIL reset_u0 got %0d/%0d exp 0/0", s0, c0);
        end
        checks++;
        if (int'(s1) !== 0 || int'(c1) !== 0) begin
            failures++;
            $display("FAIL reset_u1 got %0d/%0d exp 0/0", s1, c1);
        end
    endtask

    task automatic test_const;
        do_reset();
        phi_inc = 0;
        dither_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1);
            checks++;
            if (int'(s0) !== S0 || int'(c0) !== C0) begin
                failures++;
                $display("FAIL const_u0 i=%0d got %0d/%0d exp %0d/%0d", i, s0, c0, S0, C0);
            end
            checks++;
            if (int'(s1) !== (i == 0 ? 0 : S0) || int'(c1) !== (i == 0 ? 0 : C0)) begin
                failures++;
                $display("FAIL const_u1 i=%0d got %0d/%0d", i, s1, c1);
            end
        end
    endtask

    task automatic test_quarter;
        int ps[4], pc[4];
        ps = '{S0, C0, -S0, -C0};
        pc = '{C0, -S0, -C0, S0};
        do_reset();
        phi_inc = 32'h4000_0000;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            checks++;
            if (int'(s0) !== ps[i%4] || int'(c0) !== pc[i%4]) begin
                failures++;
                $display("FAIL quarter_u0 i=%0d got %0d/%0d exp %0d/%0d", i, s0, c0, ps[i%4], pc[i%4]);
            end
            checks++;
            if (int'(s1) !== e1s || int'(c1) !== e1c) begin
                failures++;
                $display("FAIL quarter_u1 i=%0d got %0d/%0d exp %0d/%0d", i, s1, c1, e1s, e1c);
            end
        end
    endtask

    task automatic test_octant;
        int es, ec;
        real mag;
        do_reset();
        phi_inc = 32'h2000_0000 + 5 * 32'h0008_0000;
        tick(1'b1);
        tick(1'b1);
        es = rnd(M * $cos((1018.0 + 0.5) * D));
        ec = rnd(M * $sin((1018.0 + 0.5) * D));
        checks++;
        if (int'(s0) !== es || int'(c0) !== ec) begin
            failures++;
            $display("FAIL octant1 got %0d/%0d exp %0d/%0d", s0, c0, es, ec);
        end
        for (int i = 0; i < 30; i++) begin
            tick(1'b1);
            mag = $sqrt(real'(s0) * real'(s0) + real'(c0) * real'(c0));
            checks++;
            if (mag > M + 2.0 || mag < M - 2.0) begin
                failures++;
                $display("FAIL magnitude i=%0d got %f exp %0d+-2", i, mag, M);
            end
            checks++;
            if (int'(s0) !== e0s || int'(c0) !== e0c) begin
                failures++;
                $display("FAIL octant_seq i=%0d got %0d/%0d exp %0d/%0d", i, s0, c0, e0s, e0c);
            end
        end
    endtask

    task automatic test_en_hold;
        logic signed [DW-1:0] hs0, hc0, hs1, hc1;
        do_reset();
        phi_inc = $urandom;
        repeat (6) tick(1'b1);
        hs0 = s0; hc0 = c0; hs1 = s1; hc1 = c1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0);
            checks++;
            if (s0 !== hs0 || c0 !== hc0 || s1 !== hs1 || c1 !== hc1) begin
                failures++;
                $display("FAIL en_hold i=%0d got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", i, s0, c0, s1, c1, hs0, hc0, hs1, hc1);
            end
        end
        tick(1'b1);
        checks++;
        if (s1 !== hs0 || c1 !== hc0) begin
            failures++;
            $display("FAIL en_resume_latency got %0d/%0d exp %0d/%0d", s1, c1, hs0, hc0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (int'(s0) !== e0s || int'(c0) !== e0c || int'(s1) !== e1s || int'(c1) !== e1c) begin
                failures++;
                $display("FAIL en_resume i=%0d got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", i, s0, c0, s1, c1, e0s, e0c, e1s, e1c);
            end
            tick(1'b1);
        end
    endtask

    task automatic test_negative;
        int ps[4];
        ps = '{S0, -C0, -S0, C0};
        do_reset();
        phi_inc = 32'hC000_0000;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            checks++;
            if (int'(s0) !== ps[i%4]) begin
                failures++;
                $display("FAIL negative_freq i=%0d got %0d exp %0d", i, s0, ps[i%4]);
            end
        end
    endtask

    task automatic test_dither;
        do_reset();
        dither_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (i % 50 == 0) phi_inc = (i == 0) ? 32'h2000_0000 : ($urandom & 32'h0000_FFFF) | 32'h0007_FF00;
            tick(1'b1);
            checks++;
            if (int'(s0) !== e0s || int'(c0) !== e0c || int'(s1) !== e1s || int'(c1) !== e1c) begin
                failures++;
                $display("FAIL dither i=%0d got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", i, s0, c0, s1, c1, e0s, e0c, e1s, e1c);
            end
        end
        dither_en = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) phi_inc = $urandom;
            dither_en = $urandom_range(0, 1) == 1;
            tick($urandom_range(0, 3) != 0);
            checks++;
            if (int'(s0) !== e0s || int'(c0) !== e0c || int'(s1) !== e1s || int'(c1) !== e1c) begin
                failures++;
                $display("FAIL back_to_back i=%0d got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", i, s0, c0, s1, c1, e0s, e0c, e1s, e1c);
            end
        end
        dither_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        phi_inc = $urandom | 32'h1000_0000;
        repeat (10) tick(1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (int'(s0) !== 0 || int'(c0) !== 0 || int'(s1) !== 0 || int'(c1) !== 0) begin
            failures++;
            $display("FAIL reset_mid got %0d/%0d %0d/%0d exp zeros", s0, c0, s1, c1);
        end
        model_reset();
        en = 1'b0;
        phi_inc = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            checks++;
            if (int'(s0) !== S0 || int'(c0) !== C0 || int'(s1) !== (i == 0 ? 0 : S0) || int'(c1) !== (i == 0 ? 0 : C0)) begin
                failures++;
                $display("FAIL reset_restart i=%0d got %0d/%0d %0d/%0d exp %0d/%0d", i, s0, c0, s1, c1, S0, C0);
            end
        end
    endtask

    initial begin
        S0 = rnd(M * $sin(0.5 * D));
        C0 = rnd(M * $cos(0.5 * D));
        model_reset();
        test_reset();
        test_const();
        test_quarter();
        test_octant();
        test_en_hold();
        test_negative();
        test_dither();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
